// File: rtl/mem_loader.sv
// Boot loader in front of the 64K system memory: takes a framed byte stream
// (base, length, payload, optional checksum), writes the payload, then hands the bus to the CPU.
module mem_loader #(
   parameter bit LOAD_ENABLE = 1'b1,
   parameter bit CHECK_SUM   = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        InValid,
   input  logic [7:0]  InData,
   output logic        InReady,
   input  logic        CpuWE,
   input  logic [15:0] CpuAddress,
   input  logic [7:0]  CpuDataIn,
   output logic        MemWE,
   output logic [15:0] MemAddress,
   output logic [7:0]  MemDataIn,
   output logic        CpuHold,
   output logic        Done,
   output logic        Error
);

   typedef enum logic [2:0] {
      ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, SUM, DONE, ERR
   } state_t;

   state_t      state;
   logic [15:0] ptr;
   logic [15:0] len;
   logic [7:0]  sum;
   logic [7:0]  sum_chk;
   logic        wr_we;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        accept;
   logic        loader_owns_bus;

   assign InReady = (state != DONE) && (state != ERR);
   assign accept  = InValid && InReady;
   assign sum_chk = sum + InData;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= LOAD_ENABLE ? ADDR_LO : DONE;
         CpuHold <= LOAD_ENABLE;
         Done    <= !LOAD_ENABLE;
         Error   <= 1'b0;
         wr_we   <= 1'b0;
         wr_addr <= 16'd0;
         wr_data <= 8'd0;
         ptr     <= 16'd0;
         len     <= 16'd0;
         sum     <= 8'd0;
      end else begin
         wr_we <= 1'b0;
         if (accept) begin
            case (state)
               ADDR_LO: begin
                  ptr[7:0] <= InData;
                  state    <= ADDR_HI;
               end
               ADDR_HI: begin
                  ptr[15:8] <= InData;
                  state     <= LEN_LO;
               end
               LEN_LO: begin
                  len[7:0] <= InData;
                  state    <= LEN_HI;
               end
               LEN_HI: begin
                  len[15:8] <= InData;
                  if ({InData, len[7:0]} != 16'd0) begin
                     state <= DATA;
                  end else if (CHECK_SUM) begin
                     state <= SUM;
                  end else begin
                     state   <= DONE;
                     CpuHold <= 1'b0;
                     Done    <= 1'b1;
                  end
               end
               DATA: begin
                  // Write is registered: memory sees it on the next edge.
                  wr_we   <= 1'b1;
                  wr_addr <= ptr;
                  wr_data <= InData;
                  sum     <= sum_chk;
                  ptr     <= ptr + 16'd1;
                  len     <= len - 16'd1;
                  if (len == 16'd1) begin
                     if (CHECK_SUM) begin
                        state <= SUM;
                     end else begin
                        state   <= DONE;
                        CpuHold <= 1'b0;
                        Done    <= 1'b1;
                     end
                  end
               end
               SUM: begin
                  if (sum_chk == 8'd0) begin
                     state   <= DONE;
                     CpuHold <= 1'b0;
                     Done    <= 1'b1;
                  end else begin
                     state <= ERR;
                     Error <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // A still-pending loader write keeps the bus so the final byte lands even without a checksum cycle.
   assign loader_owns_bus = CpuHold || wr_we;
   assign MemWE      = loader_owns_bus ? wr_we   : CpuWE;
   assign MemAddress = loader_owns_bus ? wr_addr : CpuAddress;
   assign MemDataIn  = loader_owns_bus ? wr_data : CpuDataIn;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: logs every MemWE pulse and checks frames, errors,
// address wrap, gaps, zero length, pass-through and mid-frame reset.
module tb_mem_loader;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        InValid = 1'b0;
   logic [7:0]  InData = 8'd0;
   logic        InReady;
   logic        CpuWE = 1'b0;
   logic [15:0] CpuAddress = 16'd0;
   logic [7:0]  CpuDataIn = 8'd0;
   logic        MemWE;
   logic [15:0] MemAddress;
   logic [7:0]  MemDataIn;
   logic        CpuHold;
   logic        Done;
   logic        Error;

   int testsRun = 0;
   int testsFailed = 0;
   int cyc = 0;
   int markCyc;

   logic [15:0] wrAddr[$];
   logic [7:0]  wrData[$];
   int          wrCyc[$];

   mem_loader #(.LOAD_ENABLE(1'b1), .CHECK_SUM(1'b1)) dut (
      .CLK(CLK), .RST(RST), .InValid(InValid), .InData(InData), .InReady(InReady),
      .CpuWE(CpuWE), .CpuAddress(CpuAddress), .CpuDataIn(CpuDataIn),
      .MemWE(MemWE), .MemAddress(MemAddress), .MemDataIn(MemDataIn),
      .CpuHold(CpuHold), .Done(Done), .Error(Error)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Every write the memory would see, sampled mid-cycle.
   always @(negedge CLK) begin
      if (MemWE) begin
         wrAddr.push_back(MemAddress);
         wrData.push_back(MemDataIn);
         wrCyc.push_back(cyc);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      InValid = 1'b1;
      InData  = b;
      @(posedge CLK);
      #1;
      InValid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic clearLog();
      wrAddr.delete();
      wrData.delete();
      wrCyc.delete();
   endtask

   task automatic resetDut();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      clearLog();
   endtask

   initial begin
      // Reset state
      resetDut();
      checkOutput("rst_hold",  CpuHold, 1);
      checkOutput("rst_done",  Done,    0);
      checkOutput("rst_error", Error,   0);
      checkOutput("rst_ready", InReady, 1);
      checkOutput("rst_memwe", MemWE,   0);

      // CPU write attempt while held is ignored
      CpuWE = 1'b1; CpuAddress = 16'h0108; CpuDataIn = 8'h55;
      #1;
      checkOutput("held_cpu_we", MemWE, 0);
      CpuWE = 1'b0;
      #1;
      clearLog();

      // Nominal load
      applyStimulus(8'h00); applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h00);
      applyStimulus(8'hA2);
      markCyc = cyc;
      applyStimulus(8'h07); applyStimulus(8'hEA);
      checkOutput("nom_hold_before_chk", CpuHold, 1);
      applyStimulus(8'h6D);
      checkOutput("nom_done",  Done,    1);
      checkOutput("nom_hold",  CpuHold, 0);
      checkOutput("nom_error", Error,   0);
      checkOutput("nom_ready", InReady, 0);
      idle(2);
      checkOutput("nom_wr_count", wrAddr.size(), 3);
      checkOutput("nom_wr0_addr", wrAddr[0], 16'h0200);
      checkOutput("nom_wr0_data", wrData[0], 8'hA2);
      checkOutput("nom_wr1_addr", wrAddr[1], 16'h0201);
      checkOutput("nom_wr1_data", wrData[1], 8'h07);
      checkOutput("nom_wr2_addr", wrAddr[2], 16'h0202);
      checkOutput("nom_wr2_data", wrData[2], 8'hEA);
      checkOutput("nom_wr0_latency", wrCyc[0], markCyc);
      checkOutput("nom_wr1_b2b", wrCyc[1], markCyc + 1);
      checkOutput("nom_wr2_b2b", wrCyc[2], markCyc + 2);

      // Pass-through after DONE
      CpuWE = 1'b1; CpuAddress = 16'h0108; CpuDataIn = 8'h55;
      #1;
      checkOutput("pt_we",   MemWE,      1);
      checkOutput("pt_addr", MemAddress, 16'h0108);
      checkOutput("pt_data", MemDataIn,  8'h55);
      CpuAddress = 16'hBEEF; CpuDataIn = 8'h3C;
      #1;
      checkOutput("pt_addr2", MemAddress, 16'hBEEF);
      checkOutput("pt_data2", MemDataIn,  8'h3C);
      CpuWE = 1'b0;
      #1;
      checkOutput("pt_we_off", MemWE, 0);

      // Bad checksum
      resetDut();
      applyStimulus(8'h00); applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h00);
      applyStimulus(8'hA2); applyStimulus(8'h07); applyStimulus(8'hEA); applyStimulus(8'h6C);
      checkOutput("bad_error", Error,   1);
      checkOutput("bad_hold",  CpuHold, 1);
      checkOutput("bad_done",  Done,    0);
      checkOutput("bad_ready", InReady, 0);
      applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
      idle(1);
      checkOutput("bad_wr_count", wrAddr.size(), 3);
      checkOutput("bad_wr2_data", wrData[2], 8'hEA);
      checkOutput("bad_error_hold", Error, 1);

      // Address wrap with 3-cycle gaps; checksum of 11+22 is CD
      resetDut();
      applyStimulus(8'hFF); idle(3);
      applyStimulus(8'hFF); idle(3);
      applyStimulus(8'h02); idle(3);
      applyStimulus(8'h00); idle(3);
      applyStimulus(8'h11); idle(3);
      applyStimulus(8'h22); idle(3);
      checkOutput("wrap_not_done", Done, 0);
      applyStimulus(8'hCD); idle(3);
      checkOutput("wrap_wr_count", wrAddr.size(), 2);
      checkOutput("wrap_wr0_addr", wrAddr[0], 16'hFFFF);
      checkOutput("wrap_wr0_data", wrData[0], 8'h11);
      checkOutput("wrap_wr1_addr", wrAddr[1], 16'h0000);
      checkOutput("wrap_wr1_data", wrData[1], 8'h22);
      checkOutput("wrap_done",  Done,  1);
      checkOutput("wrap_error", Error, 0);

      // Zero length
      resetDut();
      applyStimulus(8'h34); applyStimulus(8'h12); applyStimulus(8'h00); applyStimulus(8'h00);
      checkOutput("zero_not_done", Done, 0);
      applyStimulus(8'h00);
      idle(1);
      checkOutput("zero_wr_count", wrAddr.size(), 0);
      checkOutput("zero_done", Done, 1);
      checkOutput("zero_hold", CpuHold, 0);

      // Reset mid-frame, right after a DATA byte is accepted
      resetDut();
      applyStimulus(8'h00); applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h00);
      applyStimulus(8'hA2);
      checkOutput("mid_strobe_pending", MemWE, 1);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      checkOutput("mid_hold",  CpuHold, 1);
      checkOutput("mid_memwe", MemWE,   0);
      checkOutput("mid_ready", InReady, 1);
      checkOutput("mid_done",  Done,    0);
      clearLog();
      // Fresh frame: 10,20 at $0300, checksum D0
      applyStimulus(8'h00); applyStimulus(8'h03); applyStimulus(8'h02); applyStimulus(8'h00);
      applyStimulus(8'h10); applyStimulus(8'h20); applyStimulus(8'hD0);
      idle(1);
      checkOutput("mid_wr_count", wrAddr.size(), 2);
      checkOutput("mid_wr0_addr", wrAddr[0], 16'h0300);
      checkOutput("mid_wr0_data", wrData[0], 8'h10);
      checkOutput("mid_wr1_addr", wrAddr[1], 16'h0301);
      checkOutput("mid_wr1_data", wrData[1], 8'h20);
      checkOutput("mid_done_after", Done, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
